// File: rtl/vis_byte_streamer.sv
// Visibility word FIFO plus byte serialiser onto an 8-bit AXI4-Stream; byte 0 two cycles after valid_i.
// Input never stalls: m_tready backpressure fills the FIFO, and pushes into a full FIFO without a pop are dropped (sticky overflow_o).

module vis_byte_fifo #(
  parameter int DW    = 65,
  parameter int ABITS = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdat,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdat,
  output logic          o_empty,
  output logic          o_full,
  output logic [ABITS:0] o_level
);
  localparam int DEPTH = 2**ABITS;
  localparam logic [ABITS:0] DEPTH_L = (ABITS+1)'(DEPTH);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [ABITS-1:0] r_wptr;
  logic [ABITS-1:0] r_rptr;
  logic [ABITS:0]   r_level;

  // Storage is not reset; occupancy and pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_wdat;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (i_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (i_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdat  = r_mem[r_rptr];
  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == DEPTH_L);
  assign o_level = r_level;
endmodule

module vis_byte_streamer #(
  parameter int WIDTH = 32,
  parameter int ABITS = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             valid_i,
  input  logic             last_i,
  input  logic [WIDTH-1:0] revis_i,
  input  logic [WIDTH-1:0] imvis_i,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [7:0]       m_tdata,
  output logic             overflow_o,
  output logic [ABITS:0]   level_o
);
  localparam int NBYTES = 2*WIDTH/8;
  localparam int EW     = 2*WIDTH + 1;
  localparam int BW     = $clog2(NBYTES);
  localparam logic [BW-1:0] LAST_B = BW'(NBYTES-1);
  localparam logic [BW-1:0] PEN_B  = BW'(NBYTES-2);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_SEND  = 1'b1;

  logic [0:0]         r_state;
  logic               r_tvalid;
  logic               r_tlast;
  logic               r_lastf;
  logic [BW-1:0]      r_bcnt;
  logic [2*WIDTH-1:0] r_shift;
  logic               r_ovf;

  logic               w_hs;
  logic               w_lastb;
  logic               w_pop;
  logic               w_push;
  logic               w_empty;
  logic               w_full;
  logic [EW-1:0]      w_rdat;

  assign w_hs    = r_tvalid && m_tready;
  assign w_lastb = (r_bcnt == LAST_B);
  // Reload straight from the FIFO on the final byte so back-to-back entries have no bubble.
  assign w_pop   = !w_empty && ((r_state == S_EMPTY) || (w_hs && w_lastb));
  assign w_push  = valid_i && (!w_full || w_pop);

  vis_byte_fifo #(
    .DW    (EW),
    .ABITS (ABITS)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_wdat  ({last_i, imvis_i, revis_i}),
    .i_pop   (w_pop),
    .o_rdat  (w_rdat),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (level_o)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_EMPTY;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_lastf  <= 1'b0;
      r_bcnt   <= '0;
      r_shift  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (valid_i && !w_push) begin
        r_ovf <= 1'b1;
      end
      if (w_pop) begin
        r_state  <= S_SEND;
        r_tvalid <= 1'b1;
        r_tlast  <= 1'b0;
        r_lastf  <= w_rdat[EW-1];
        r_bcnt   <= '0;
        r_shift  <= w_rdat[2*WIDTH-1:0];
      end else if (w_hs) begin
        if (w_lastb) begin
          r_state  <= S_EMPTY;
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
        end else begin
          // The low byte of the shift register is always the byte on the wire.
          r_bcnt  <= r_bcnt + 1'b1;
          r_shift <= r_shift >> 8;
          r_tlast <= r_lastf && (r_bcnt == PEN_B);
        end
      end
    end
  end

  assign m_tvalid   = r_tvalid;
  assign m_tlast    = r_tlast;
  assign m_tdata    = r_shift[7:0];
  assign overflow_o = r_ovf;
endmodule

// File: tb/tb_vis_byte_streamer.sv
// Directed bench for vis_byte_streamer: latency table plus backpressure, burst, overflow, full-with-pop and reset sequences.
module tb_vis_byte_streamer;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        valid_i;
  logic        last_i;
  logic [31:0] revis_i;
  logic [31:0] imvis_i;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [7:0]  m_tdata;
  logic        overflow_o;
  logic [4:0]  level_o;

  always #5 clock = ~clock;

  vis_byte_streamer #(.WIDTH(32), .ABITS(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .valid_i    (valid_i),
    .last_i     (last_i),
    .revis_i    (revis_i),
    .imvis_i    (imvis_i),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .m_tdata    (m_tdata),
    .overflow_o (overflow_o),
    .level_o    (level_o)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  typedef struct {
    logic        v;
    logic        l;
    logic [31:0] re;
    logic [31:0] im;
    logic        rdy;
    logic        tv;
    logic [7:0]  td;
    logic        tl;
    logic [4:0]  lvl;
    logic        ovf;
  } vec_t;

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t exp_q[$];
  bit   mon_en  = 1'b0;
  bit   p_stall = 1'b0;
  logic [7:0] p_dat;
  logic p_last;
  int   hs_cnt   = 0;
  int   cyc_cnt  = 0;
  int   first_hs = 0;
  int   last_hs  = 0;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic add_exp(input logic [31:0] re, input logic [31:0] im, input logic lst);
    logic [63:0] w;
    w = {im, re};
    for (int b = 0; b < 8; b++) begin
      exp_t e;
      e.d = w[7:0];
      e.l = lst && (b == 7);
      exp_q.push_back(e);
      w = w >> 8;
    end
  endtask

  task automatic push1(input logic [31:0] re, input logic [31:0] im, input logic lst);
    valid_i = 1'b1;
    last_i  = lst;
    revis_i = re;
    imvis_i = im;
    add_exp(re, im, lst);
    step();
    valid_i = 1'b0;
  endtask

  task automatic drain(input int budget, input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk({nm, "_left"}, exp_q.size(), 0);
    @(negedge clock);
    chk({nm, "_idle"}, m_tvalid, 0);
    step();
  endtask

  task automatic do_reset();
    mon_en  = 1'b0;
    reset_n = 1'b0;
    valid_i = 1'b0;
    m_tready = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    step();
    mon_en = 1'b1;
  endtask

  // Scoreboard on every handshake, plus AXI hold rules while stalled.
  always @(negedge clock) begin
    exp_t e;
    cyc_cnt++;
    if (mon_en) begin
      if (p_stall) begin
        chk("hold_vld", m_tvalid, 1);
        chk("hold_dat", m_tdata, p_dat);
        chk("hold_last", m_tlast, p_last);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL extra_byte: got %0h want none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("byte", m_tdata, e.d);
          chk("last", m_tlast, e.l);
        end
        if (hs_cnt == 0) first_hs = cyc_cnt;
        last_hs = cyc_cnt;
        hs_cnt++;
      end
      p_stall = m_tvalid && !m_tready;
      p_dat   = m_tdata;
      p_last  = m_tlast;
    end else begin
      p_stall = 1'b0;
    end
  end

  initial begin
    reset_n  = 1'b0;
    valid_i  = 1'b0;
    last_i   = 1'b0;
    revis_i  = '0;
    imvis_i  = '0;
    m_tready = 1'b0;

    for (int i = 0; i < 12; i++) begin
      tbl[i].v = 0; tbl[i].l = 0; tbl[i].re = '0; tbl[i].im = '0; tbl[i].rdy = 1;
      tbl[i].tv = 0; tbl[i].td = '0; tbl[i].tl = 0; tbl[i].lvl = '0; tbl[i].ovf = 0;
    end
    tbl[0].v  = 1;
    tbl[0].l  = 1;
    tbl[0].re = 32'h04030201;
    tbl[0].im = 32'h08070605;
    tbl[1].lvl = 5'd1;
    for (int i = 2; i < 10; i++) begin
      tbl[i].tv = 1;
      tbl[i].td = 8'(i - 1);
    end
    tbl[9].tl = 1;

    repeat (3) @(negedge clock);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_level", level_o, 0);
    reset_n = 1'b1;
    step();

    // Single entry, ready held high: byte 0 in cycle 2, tlast only on byte 08.
    for (int i = 0; i < 12; i++) begin
      valid_i  = tbl[i].v;
      last_i   = tbl[i].l;
      revis_i  = tbl[i].re;
      imvis_i  = tbl[i].im;
      m_tready = tbl[i].rdy;
      @(negedge clock);
      chk($sformatf("tbl%0d_tvalid", i), m_tvalid, tbl[i].tv);
      if (tbl[i].tv) chk($sformatf("tbl%0d_tdata", i), m_tdata, tbl[i].td);
      chk($sformatf("tbl%0d_tlast", i), m_tlast, tbl[i].tl);
      chk($sformatf("tbl%0d_level", i), level_o, tbl[i].lvl);
      chk($sformatf("tbl%0d_ovf", i), overflow_o, tbl[i].ovf);
      step();
    end
    valid_i = 1'b0;
    mon_en  = 1'b1;

    // Backpressure: ready pattern 1,0,0,1 repeating.
    hs_cnt   = 0;
    m_tready = 1'b1;
    push1(32'h04030201, 32'h08070605, 1'b1);
    for (int k = 1; k < 40 && exp_q.size() != 0; k++) begin
      m_tready = (k % 4 == 0) || (k % 4 == 3);
      step();
    end
    m_tready = 1'b1;
    chk("bp_left", exp_q.size(), 0);
    chk("bp_count", hs_cnt, 8);
    @(negedge clock);
    chk("bp_idle", m_tvalid, 0);
    step();

    // Three back-to-back entries: 24 contiguous bytes.
    hs_cnt = 0;
    push1(32'h13121110, 32'h17161514, 1'b0);
    push1(32'h23222120, 32'h27262524, 1'b0);
    push1(32'h33323130, 32'h37363534, 1'b1);
    drain(100, "b2b");
    chk("b2b_count", hs_cnt, 24);
    chk("b2b_span", last_hs - first_hs, 23);

    // Overflow: 18 pushes while stalled, the 18th dropped.
    hs_cnt   = 0;
    m_tready = 1'b0;
    for (int k = 0; k < 18; k++) begin
      valid_i = 1'b1;
      last_i  = (k == 16);
      revis_i = 32'h03020100 + k * 32'h04040404;
      imvis_i = revis_i ^ 32'h80808080;
      if (k < 17) add_exp(revis_i, imvis_i, last_i);
      @(negedge clock);
      if (k == 17) begin
        chk("ovf_lvl_full", level_o, 16);
        chk("ovf_not_yet", overflow_o, 0);
      end
      step();
    end
    valid_i = 1'b0;
    @(negedge clock);
    chk("ovf_set", overflow_o, 1);
    chk("ovf_lvl_hold", level_o, 16);
    chk("ovf_stall_vld", m_tvalid, 1);
    step();
    m_tready = 1'b1;
    drain(300, "ovf");
    chk("ovf_count", hs_cnt, 136);
    chk("ovf_sticky", overflow_o, 1);

    // Full FIFO with a push on the last-byte handshake cycle.
    do_reset();
    hs_cnt = 0;
    for (int k = 0; k < 17; k++) begin
      valid_i = 1'b1;
      last_i  = 1'b0;
      revis_i = 32'h83828180 + k * 32'h01010101;
      imvis_i = revis_i + 32'h40404040;
      add_exp(revis_i, imvis_i, 1'b0);
      step();
    end
    valid_i  = 1'b0;
    m_tready = 1'b1;
    repeat (7) step();
    valid_i = 1'b1;
    last_i  = 1'b1;
    revis_i = 32'hF3F2F1F0;
    imvis_i = 32'hF7F6F5F4;
    add_exp(revis_i, imvis_i, 1'b1);
    @(negedge clock);
    chk("full_lvl_pre", level_o, 16);
    step();
    valid_i = 1'b0;
    @(negedge clock);
    chk("full_lvl_post", level_o, 16);
    chk("full_ovf", overflow_o, 0);
    step();
    drain(300, "full");
    chk("full_count", hs_cnt, 144);

    // Reset after byte 3 of an entry with another entry queued.
    hs_cnt = 0;
    m_tready = 1'b1;
    push1(32'hC3C2C1C0, 32'hC7C6C5C4, 1'b1);
    push1(32'hD3D2D1D0, 32'hD7D6D5D4, 1'b1);
    repeat (4) step();
    chk("rst_pre_bytes", hs_cnt, 4);
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_tvalid", m_tvalid, 0);
    chk("midrst_tlast", m_tlast, 0);
    chk("midrst_tdata", m_tdata, 0);
    chk("midrst_ovf", overflow_o, 0);
    chk("midrst_level", level_o, 0);
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    step();
    hs_cnt = 0;
    mon_en = 1'b1;
    valid_i = 1'b1;
    last_i  = 1'b1;
    revis_i = 32'hE3E2E1E0;
    imvis_i = 32'hE7E6E5E4;
    add_exp(revis_i, imvis_i, 1'b1);
    @(negedge clock);
    chk("post_c0_vld", m_tvalid, 0);
    step();
    valid_i = 1'b0;
    @(negedge clock);
    chk("post_c1_vld", m_tvalid, 0);
    chk("post_c1_lvl", level_o, 1);
    step();
    @(negedge clock);
    chk("post_c2_vld", m_tvalid, 1);
    chk("post_c2_dat", m_tdata, 8'hE0);
    step();
    drain(50, "post");
    chk("post_count", hs_cnt, 8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
